// File: rtl/key_scan_pkg.sv
// Shared constants, FSM state encoding and code helpers for the key matrix
// scanner. Optional feature macro used by this slice: KEY_SCAN_REPEAT_EN.
package key_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 5;
  localparam int CODE_W   = 5;

  localparam logic [CODE_W-1:0] KEY_NONE    = 5'd0;
  localparam logic [CODE_W-1:0] KEY_INVALID = 5'd31;

  // Legacy-compatible state encoding
  typedef logic [0:0] state_t;
  localparam state_t SCAN = 1'b0;
  localparam state_t EVAL = 1'b1;

  // True for codes that represent a real key (single keys and row combos)
  function automatic logic is_key(input logic [CODE_W-1:0] code);
    return (code >= 5'd1) && (code <= 5'd24);
  endfunction

endpackage

// File: rtl/key_scan_if.sv
// Matrix-side and host-side signals of the key scanner bundled together.
// slave = scanner side, master = matrix/consumer side.
interface key_scan_if;
  import key_scan_pkg::*;

  logic [NUM_ROWS-1:0] key_row_in;
  logic [NUM_COLS-1:0] key_column_out;
  logic [CODE_W-1:0]   key_code;
  logic                key_valid;
  logic                key_pressed;

  modport slave (
    input  key_row_in,
    output key_column_out, key_code, key_valid, key_pressed
  );

  modport master (
    output key_row_in,
    input  key_column_out, key_code, key_valid, key_pressed
  );

endinterface

// File: rtl/key_scan_debounce.sv
// Frame-level debouncer: commits a code after DEBOUNCE_FRAMES identical
// frames and pulses key_valid for newly committed key codes.
// KEY_SCAN_REPEAT_EN adds auto-repeat pulses while a key stays committed.
module key_scan_debounce
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 200,
  parameter int REPEAT_RATE     = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_done,
  input  logic [CODE_W-1:0] i_frame_code,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_valid,
  output logic              o_key_pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic [CODE_W-1:0] r_cand, r_committed, r_code;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid, r_pressed;

  logic [CODE_W-1:0] w_cand_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic              w_commit;
  logic              w_rpt_fire;

  // Next candidate/count for the frame currently being evaluated
  always_comb begin
    w_cand_n = r_cand;
    w_cnt_n  = r_cnt;
    if (i_frame_code == r_cand) begin
      if (r_cnt != CNT_W'(DEBOUNCE_FRAMES))
        w_cnt_n = r_cnt + CNT_W'(1);
    end else begin
      w_cand_n = i_frame_code;
      w_cnt_n  = CNT_W'(1);
    end
    w_commit = i_frame_done && (w_cnt_n == CNT_W'(DEBOUNCE_FRAMES)) &&
               (w_cand_n != r_committed);
  end

`ifdef KEY_SCAN_REPEAT_EN
  localparam int RPT_W = 16;

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first;
  logic [RPT_W-1:0] w_rpt_next, w_rpt_target;

  // Repeat fires when the frames since the last pulse reach the current target
  always_comb begin
    w_rpt_next   = r_rpt_cnt + RPT_W'(1);
    w_rpt_target = r_rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
    w_rpt_fire   = i_frame_done && !w_commit && is_key(r_committed) &&
                   (w_rpt_next == w_rpt_target);
  end

  // Frame counter for held keys; restarts on any change of the committed code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_commit || !is_key(r_committed)) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (i_frame_done) begin
      if (w_rpt_fire) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b0;
      end else begin
        r_rpt_cnt   <= w_rpt_next;
      end
    end
  end
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
  assign w_rpt_fire   = 1'b0;
`endif

  // Debounce state and registered outputs; release/invalid commits never pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cand      <= KEY_NONE;
      r_cnt       <= '0;
      r_committed <= KEY_NONE;
      r_code      <= KEY_NONE;
      r_valid     <= 1'b0;
      r_pressed   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_frame_done) begin
        r_cand <= w_cand_n;
        r_cnt  <= w_cnt_n;
      end
      if (w_commit) begin
        r_committed <= w_cand_n;
        r_pressed   <= is_key(w_cand_n);
        if (is_key(w_cand_n)) begin
          r_code  <= w_cand_n;
          r_valid <= 1'b1;
        end
      end else if (w_rpt_fire) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign o_key_code    = r_code;
  assign o_key_valid   = r_valid;
  assign o_key_pressed = r_pressed;

endmodule

// File: rtl/key_scan.sv
// 4x5 key matrix scanner: column drive FSM, row synchronizer and per-frame
// code encoder, feeding the frame debouncer.
// Optional feature macro: KEY_SCAN_REPEAT_EN (auto-repeat in the debouncer).
module key_scan
  import key_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 100,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 200,
  parameter int REPEAT_RATE     = 40
) (
  input  logic        clk,
  input  logic        rst,
  key_scan_if.slave   bus
);

  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int ACT_W = NUM_COLS * NUM_ROWS;

  logic [NUM_ROWS-1:0] r_row_s1, r_row_s2;
  logic [NUM_ROWS-1:0] r_row_cap [NUM_COLS];
  logic [NUM_COLS-1:0] r_col_drv;
  state_t              r_state;
  logic [1:0]          r_col;
  logic [SET_W-1:0]    r_settle;

  logic [ACT_W-1:0]    w_act;
  logic [CODE_W-1:0]   w_frame_code;
  logic                w_frame_done;

  // Classify one scan frame; bit c*NUM_ROWS+k of act is column c, row k pressed
  function automatic logic [CODE_W-1:0] encode(input logic [ACT_W-1:0] act);
    int unsigned       nbits;
    logic [CODE_W-1:0] pos, combo;
    logic              has_combo;
    nbits     = 0;
    pos       = KEY_NONE;
    combo     = KEY_NONE;
    has_combo = 1'b0;
    for (int i = 0; i < ACT_W; i++) begin
      if (act[i]) begin
        nbits++;
        pos = CODE_W'(i + 1);
      end
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      if (act[c*NUM_ROWS +: NUM_ROWS] == 5'b10001) begin
        has_combo = 1'b1;
        combo     = CODE_W'(21 + c);
      end
    end
    if (nbits == 0)                    return KEY_NONE;
    else if (nbits == 1)               return pos;
    else if (nbits == 2 && has_combo)  return combo;
    else                               return KEY_INVALID;
  endfunction

  // Two-flop synchronizer for the asynchronous row lines (idle high)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= bus.key_row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  // Scan FSM: settle each column, capture its rows, then one EVAL cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= SCAN;
      r_col    <= 2'd0;
      r_settle <= '0;
      for (int c = 0; c < NUM_COLS; c++) r_row_cap[c] <= '1;
    end else begin
      case (r_state)
        SCAN: begin
          if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
            r_row_cap[r_col] <= r_row_s2;
            r_settle         <= '0;
            r_col            <= r_col + 2'd1;
            if (r_col == 2'd3) r_state <= EVAL;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        EVAL: begin
          r_col   <= 2'd0;
          r_state <= SCAN;
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  // Registered column drive: idle while in reset, column 3 held through EVAL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_col_drv <= '1;
    else if (r_state == EVAL)
      r_col_drv <= 4'b0111;
    else
      r_col_drv <= ~(4'b0001 << r_col);
  end

  // Rows are active-low; invert captures into a flat pressed-key vector
  always_comb begin
    w_act = '0;
    for (int c = 0; c < NUM_COLS; c++)
      w_act[c*NUM_ROWS +: NUM_ROWS] = ~r_row_cap[c];
  end

  assign w_frame_code       = encode(w_act);
  assign w_frame_done       = (r_state == EVAL);
  assign bus.key_column_out = r_col_drv;

  key_scan_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .i_frame_done  (w_frame_done),
    .i_frame_code  (w_frame_code),
    .o_key_code    (bus.key_code),
    .o_key_valid   (bus.key_valid),
    .o_key_pressed (bus.key_pressed)
  );

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: matrix model on the rows, directed key scenarios,
// scoreboard of expected (code, frame) pulses checked by a separate monitor.
module tb_key_scan;
  import key_scan_pkg::*;

  localparam int FRAME = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] keys [4];
  logic [4:0] w_rows;
  int edges = 0;
  int tests = 0;
  int fails = 0;

  typedef struct { logic [4:0] code; int frame; } exp_t;
  exp_t q[$];

  key_scan_if bus();

  key_scan #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_FRAMES (2),
    .REPEAT_DELAY    (3),
    .REPEAT_RATE     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven
  always_comb begin
    w_rows = 5'b11111;
    for (int c = 0; c < 4; c++)
      if (!bus.key_column_out[c]) w_rows = w_rows & ~keys[c];
    bus.key_row_in = w_rows;
  end

  // Active clock edges since reset release; frame m ends on edge 17*m
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic push(input logic [4:0] code, input int frame);
    exp_t e;
    e.code  = code;
    e.frame = frame;
    q.push_back(e);
  endtask

  task automatic frames(input int n);
    repeat (FRAME * n) @(negedge clk);
  endtask

  // Monitor: every key_valid pulse must match the next expected entry
  always @(negedge clk) begin
    if (rst && bus.key_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: code %0d at edge %0d, none expected",
                 bus.key_code, edges);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_code", int'(bus.key_code), int'(e.code));
        check("pulse_edge", edges, e.frame * FRAME);
      end
    end
  end

  initial begin
    #200000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [3:0] exp_col;
    for (int c = 0; c < 4; c++) keys[c] = 5'b0;

    // Reset state and column sequence of the first frame
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_col", int'(bus.key_column_out), 15);
    check("rst_code", int'(bus.key_code), 0);
    check("rst_valid", int'(bus.key_valid), 0);
    check("rst_pressed", int'(bus.key_pressed), 0);
    rst = 1'b1;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (i <= 4)       exp_col = 4'b1110;
      else if (i <= 8)  exp_col = 4'b1101;
      else if (i <= 12) exp_col = 4'b1011;
      else              exp_col = 4'b0111;
      check("col_seq", int'(bus.key_column_out), int'(exp_col));
    end

    // Single key: column 2 row 3 -> 14, from frame 2
    keys[2] = 5'b01000;
    push(5'd14, 3);
    frames(2);
    check("k14_pressed", int'(bus.key_pressed), 1);
    check("k14_code", int'(bus.key_code), 14);
    keys[2] = 5'b0;
    frames(1);
    check("k14_hold_pressed", int'(bus.key_pressed), 1);
    frames(1);
    check("k14_rel_pressed", int'(bus.key_pressed), 0);
    check("k14_rel_code", int'(bus.key_code), 14);

    // Row combo on column 1 -> 22, then two columns -> invalid
    keys[1] = 5'b10001;
    push(5'd22, 7);
    frames(2);
    check("k22_pressed", int'(bus.key_pressed), 1);
    check("k22_code", int'(bus.key_code), 22);
    keys[0] = 5'b00001;
    keys[1] = 5'b00001;
    frames(2);
    check("inv_pressed", int'(bus.key_pressed), 0);
    check("inv_code", int'(bus.key_code), 22);
    keys[0] = 5'b0;
    keys[1] = 5'b0;
    frames(2);

    // Bounce: key 7 alternates for 6 frames, then holds (frames 18, 19)
    for (int i = 0; i < 6; i++) begin
      keys[1] = (i % 2 == 0) ? 5'b00010 : 5'b00000;
      frames(1);
    end
    keys[1] = 5'b00010;
    push(5'd7, 19);
    frames(2);
    check("k7_code", int'(bus.key_code), 7);
    check("k7_pressed", int'(bus.key_pressed), 1);
    keys[1] = 5'b0;
    frames(2);
    check("k7_rel_pressed", int'(bus.key_pressed), 0);

    // Reset in column 2 of the second debounce frame of key 5
    keys[0] = 5'b10000;
    frames(1);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_col", int'(bus.key_column_out), 15);
    check("mid_rst_code", int'(bus.key_code), 0);
    check("mid_rst_valid", int'(bus.key_valid), 0);
    check("mid_rst_pressed", int'(bus.key_pressed), 0);
    rst = 1'b1;
    push(5'd5, 2);
    frames(2);
    check("k5_code", int'(bus.key_code), 5);
    check("k5_pressed", int'(bus.key_pressed), 1);
    keys[0] = 5'b0;
    frames(2);
    check("k5_rel_pressed", int'(bus.key_pressed), 0);

    // Hold key 20 for frames 5..12; commit at frame 6
    keys[3] = 5'b10000;
    push(5'd20, 6);
`ifdef KEY_SCAN_REPEAT_EN
    push(5'd20, 9);
    push(5'd20, 11);
    push(5'd20, 13);
`endif
    frames(8);
    check("k20_code", int'(bus.key_code), 20);
    check("k20_pressed", int'(bus.key_pressed), 1);
    keys[3] = 5'b0;
    frames(4);
    check("k20_rel_pressed", int'(bus.key_pressed), 0);

    check("scoreboard_left", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_scan.md
# key_scan

Scanning controller for the 4-column × 5-row key matrix, sitting at the opposite end of the matrix from the keypad. It drives one column low at a time, samples the five row lines, and encodes each scan frame into a key code. It debounces the code across frames and emits a one-cycle `key_valid` pulse with `key_code` for each debounced press.

## Interface
- `SETTLE_CYCLES`, default 100: cycles each column is driven before rows are sampled (10 µs at 10 MHz); minimum 4.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical frames required to commit a code; minimum 1.
- `REPEAT_DELAY`, default 200: frames from commit to first auto-repeat (used only with the macro).
- `REPEAT_RATE`, default 40: frames between subsequent auto-repeats (used only with the macro).
- `clk` input 1: 10 MHz system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `key_row_in` input 5: row lines from the matrix, active-low, asynchronous.
- `key_column_out` output 4: column drive, one-hot-low.
- `key_code` output 5: last committed valid code (1..24).
- `key_valid` output 1: one-cycle pulse when `key_code` is updated.
- `key_pressed` output 1: level, high while the committed code is 1..24.

## Operation
- **Row synchronizer:** `key_row_in` passes through a 2-flop synchronizer before sampling.
- **FSM states:**
  - `SCAN`: drives column `col` (0..3); `key_column_out` = ~(1<<col). A settle counter counts 0..SETTLE_CYCLES-1. On the last count, the synchronized rows are captured into `row_cap[col]`, the counter clears, and `col` increments. After column 3 is captured, the FSM goes to `EVAL`.
  - `EVAL`: lasts one cycle. Column drive stays at column 3. The FSM computes `frame_code`, updates the debouncer, sets `col` to 0, and returns to `SCAN`.
- **frame_code rules** (r = ~row_cap[c]):
  - No bits set in any column: code 0 (`KEY_NONE`).
  - Exactly one bit set overall, at column c, row k: code c*5 + k + 1 (1..20).
  - Exactly one column with r = 5'b10001: code 21 + c (21..24).
  - Anything else: code 31 (`KEY_INVALID`).
- **Debouncer** (state: `cand`, `cnt`, `committed`):
  - If `frame_code` == `cand`, `cnt` increments, saturating at DEBOUNCE_FRAMES. Otherwise `cand` ← `frame_code` and `cnt` ← 1.
  - When `cnt` reaches DEBOUNCE_FRAMES and `cand` ≠ `committed`, then `committed` ← `cand`.
  - If the new `committed` value is 1..24, `key_code` ← `cand` and `key_valid` pulses.
- **Release and invalid codes:**
  - Committing 0 (release) or 31 produces no pulse and leaves `key_code` unchanged.
  - 31 clears `key_pressed`.
  - A transition 31 → valid code produces a pulse.
- **Same key pressed twice:** re-pressing the same key requires an intervening committed 0, so it pulses again.

## Timing
- **Frame length:** 4·SETTLE_CYCLES + 1 cycles.
- **Reset values:**
  - `key_column_out` = 4'b1111 while `rst` is low.
  - `key_code` = 0, `key_valid` = 0, `key_pressed` = 0.
  - FSM in `SCAN` with col = 0, counters = 0, `cand` = `committed` = 0.
- **First drive after reset:** the first clock after `rst` deasserts drives 4'b1110.
- **Pulse timing:** `key_valid` and the updated `key_code` are registered and assert the cycle after the committing `EVAL`. `key_pressed` updates in that same cycle.
- **Press latency:** a press stable from the start of a frame commits at the `EVAL` of its DEBOUNCE_FRAMES-th frame.
- **Sample point:** rows sampled on settle count SETTLE_CYCLES-1 reflect the matrix from 2 cycles earlier because of the synchronizer.
- **Reset mid-frame:** discards the partial frame and all debounce state, with no pulse.
- **Pulse spacing:** `key_valid` never asserts on two consecutive cycles.

## Configuration
- Macro `KEY_SCAN_REPEAT_EN`: adds auto-repeat for keys held down.
  - **Defined:** while `committed` is 1..24, a frame counter runs. `key_valid` re-pulses with the same `key_code` after REPEAT_DELAY frames, then every REPEAT_RATE frames. Any change of `committed` clears the counter.
  - **Undefined:** exactly one pulse per debounced press. The repeat counter is not built, and REPEAT_* are ignored.

## Structure
- **Package `key_scan_pkg`:**
  - Constants `KEY_NONE` = 5'd0, `KEY_INVALID` = 5'd31, `NUM_COLS` = 4, `NUM_ROWS` = 5, `CODE_W` = 5.
  - FSM state typedef (`SCAN`, `EVAL`).
- **Sub-module `key_scan_debounce`:** contains `cand`/`cnt`/`committed`, the `key_valid`/`key_code`/`key_pressed` registers, and the optional repeat counter. It takes `frame_code` plus a one-cycle `frame_done` strobe.
- **Top level:** contains the FSM, the synchronizer, the column drive, and the `frame_code` encoder.

## Test plan
Bench parameters: SETTLE_CYCLES = 4, DEBOUNCE_FRAMES = 2. A matrix model drives the rows from `key_column_out`. Frame = 17 cycles.
- **Reset:** hold `rst` low for 5 cycles → `key_column_out` = 1111 and all outputs 0. Release → column sequence 1110, 1101, 1011, 0111, each held 4 cycles, then one `EVAL` cycle.
- **Single key:** press column 2, row 3 from frame start → single `key_valid` with `key_code` = 14 one cycle after the 2nd frame's `EVAL`; `key_pressed` = 1. Release → `key_pressed` = 0 after 2 frames, no pulse.
- **Two-row combo:** rows 0 and 4 low on column 1 → `key_code` = 22. Column 0 row 0 plus column 1 row 0 → code 31, no pulse, `key_pressed` = 0.
- **Bounce:** key 7 toggles every other frame for 6 frames, then holds → no pulse until 2 stable frames, then exactly one pulse, code 7.
- **Reset mid-operation:** assert `rst` mid-column-2 during the debounce of key 5 → no pulse, outputs 0. Key still held after release → pulse, code 5, after 2 full frames.
- **Repeat** (`KEY_SCAN_REPEAT_EN`, REPEAT_DELAY = 3, REPEAT_RATE = 2): hold key 20 → pulses at the commit, then at commit + 3 frames, then every 2 frames; stops on release.
